// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle MIPS core front end.
package cpu_defs;

  localparam int unsigned XLEN = 32;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_VALID   = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR    = 32'h0000_4180;
  localparam logic [XLEN-1:0] EXC_VECTOR_BT = 32'hBFC0_0380;

  // True when the low address bits select a whole word
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_counter.sv
// Enable/wrap event counter, reusable for performance counters.
module fetch_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, wrapping modulo 2^W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch sequencer of the multicycle MIPS core.
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_pause,
  input  logic               i_pc_load,
  input  logic [31:0]        i_next_pc,
  input  logic               i_flush,
  input  logic [31:0]        i_flush_pc,
  output logic               o_imem_req,
  output logic [31:0]        o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [31:0]        i_imem_rdata,
  output logic               o_valid,
  output logic [31:0]        o_pc,
  output logic [31:0]        o_instr,
  output logic               o_adel,
  output logic [COUNT_W-1:0] o_fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  flush_pc_q, flush_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic         adel_q, adel_d;
  logic         count_en_c;
  logic         flush_ok_c;
  logic         load_ok_c;
  logic [31:0]  target_c;

  // Redirects are only honoured while not paused
  assign flush_ok_c = i_flush & ~i_pause;
  assign load_ok_c  = i_pc_load & ~i_pause;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      flush_pc_q <= RESET_PC;
      instr_q    <= NOP_WORD;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      adel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_pc_q <= flush_pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      adel_q     <= adel_d;
    end
  end

  // Next-state and next-datapath logic; a request, once raised, holds until ack
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_pc_d = flush_pc_q;
    instr_d    = instr_q;
    req_d      = req_q;
    valid_d    = valid_q;
    adel_d     = adel_q;
    count_en_c = 1'b0;
    target_c   = flush_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (req_q) begin
          if (i_imem_ack) begin
            req_d = 1'b0;
            if (flush_ok_c) begin
              pc_d  = i_flush_pc;
              req_d = word_aligned(i_flush_pc[1:0]);
            end else begin
              instr_d    = i_imem_rdata;
              valid_d    = 1'b1;
              adel_d     = 1'b0;
              state_d    = S_VALID;
              count_en_c = 1'b1;
            end
          end else if (flush_ok_c) begin
            flush_pc_d = i_flush_pc;
            state_d    = S_DISCARD;
          end
        end else if (!i_pause) begin
          // Idle REQ cycle: after reset or when the PC is misaligned
          if (i_flush) begin
            pc_d  = i_flush_pc;
            req_d = word_aligned(i_flush_pc[1:0]);
          end else if (!word_aligned(pc_q[1:0])) begin
            instr_d    = NOP_WORD;
            valid_d    = 1'b1;
            adel_d     = 1'b1;
            state_d    = S_VALID;
            count_en_c = 1'b1;
          end else begin
            req_d = 1'b1;
          end
        end
      end
      S_VALID: begin
        if (flush_ok_c || load_ok_c) begin
          target_c = flush_ok_c ? i_flush_pc : i_next_pc;
          pc_d     = target_c;
          req_d    = word_aligned(target_c[1:0]);
          valid_d  = 1'b0;
          adel_d   = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_DISCARD: begin
        if (i_imem_ack) begin
          target_c = flush_ok_c ? i_flush_pc : flush_pc_q;
          pc_d     = target_c;
          req_d    = word_aligned(target_c[1:0]);
          state_d  = S_REQ;
        end else if (flush_ok_c) begin
          flush_pc_d = i_flush_pc;
        end
      end
      default: begin
        state_d = S_REQ;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Retired-fetch counter: one tick per entry into VALID
  fetch_counter #(
    .W (COUNT_W)
  ) u_fetch_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (count_en_c),
    .count (o_fetch_count)
  );

  assign o_imem_req  = req_q;
  assign o_imem_addr = pc_q;
  assign o_valid     = valid_q;
  assign o_pc        = pc_q;
  assign o_instr     = instr_q;
  assign o_adel      = adel_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected presentations, monitor pops them.
module tb_fetch_unit;

  localparam int unsigned COUNT_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_pause = 1'b0;
  logic               i_pc_load = 1'b0;
  logic [31:0]        i_next_pc = 32'h0;
  logic               i_flush = 1'b0;
  logic [31:0]        i_flush_pc = 32'h0;
  logic               i_imem_ack = 1'b0;
  logic [31:0]        i_imem_rdata = 32'h0;
  logic               o_imem_req;
  logic [31:0]        o_imem_addr;
  logic               o_valid;
  logic [31:0]        o_pc;
  logic [31:0]        o_instr;
  logic               o_adel;
  logic [COUNT_W-1:0] o_fetch_count;

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pause       (i_pause),
    .i_pc_load     (i_pc_load),
    .i_next_pc     (i_next_pc),
    .i_flush       (i_flush),
    .i_flush_pc    (i_flush_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_adel        (o_adel),
    .o_fetch_count (o_fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned model_count = 0;
  int          imem_delay = 1;

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0005;
    if (a == 32'h0000_3008) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch of pc presents mem[pc] (or NOP+adel if misaligned) with the next count
  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    logic mis;
    mis = (pc[1:0] != 2'b00);
    model_count++;
    e.pc    = pc;
    e.instr = mis ? 32'h0 : mem_word(pc);
    e.adel  = mis;
    e.count = 32'(model_count);
    exp_q.push_back(e);
  endtask

  // Instruction memory responder: acks after imem_delay waiting cycles
  int wcnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        i_imem_ack = 1'b0;
        wcnt = 0;
      end else if (o_imem_req === 1'b1) begin
        if (wcnt >= imem_delay) begin
          i_imem_ack   = 1'b1;
          i_imem_rdata = mem_word(o_imem_addr);
          wcnt = 0;
        end else begin
          i_imem_ack   = 1'b0;
          i_imem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        i_imem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: request protocol checks and scoreboard pop on each new presentation
  logic        prev_valid = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  exp_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_valid = 1'b0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("req_held", 32'(o_imem_req), 32'h1);
          check("addr_stable", o_imem_addr, pend_addr);
        end
        if (o_imem_req === 1'b1) check("req_aligned", 32'(o_imem_addr[1:0]), 32'h0);
        if (o_valid === 1'b1 && !prev_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_present: pc %h instr %h presented, expected no presentation", o_pc, o_instr);
          end else begin
            mon_e = exp_q.pop_front();
            check("present_pc", o_pc, mon_e.pc);
            check("present_instr", o_instr, mon_e.instr);
            check("present_adel", 32'(o_adel), 32'(mon_e.adel));
            check("present_count", o_fetch_count, mon_e.count);
          end
        end
        prev_valid = (o_valid === 1'b1);
        pend       = (o_imem_req === 1'b1) && !i_imem_ack;
        pend_addr  = o_imem_addr;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) cyc();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d fetches pending after 60 cycles, expected 0", exp_q.size());
      exp_q.delete();
    end
    cyc();
  endtask

  task automatic load(input logic [31:0] a);
    i_next_pc = a;
    i_pc_load = 1'b1;
    cyc();
    i_pc_load = 1'b0;
    i_next_pc = $urandom;
  endtask

  task automatic flush(input logic [31:0] a);
    i_flush_pc = a;
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    i_flush_pc = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_req"}, 32'(o_imem_req), 32'h0);
    check({tag, "_count"}, o_fetch_count, 32'h0);
    check({tag, "_instr"}, o_instr, 32'h0);
    check({tag, "_adel"}, 32'(o_adel), 32'h0);
    check({tag, "_pc"}, o_pc, 32'h0000_3000);
  endtask

  int          v;
  int          pn;
  logic [31:0] a, b, c, s_pc, s_instr, s_cnt;
  logic        found;

  initial begin
    #1 rst = 1'b1;
    repeat (2) cyc();
    check_reset_values("reset");

    // First fetch after reset, ack one cycle after request
    imem_delay = 1;
    rst = 1'b0;
    expect_fetch(32'h0000_3000);
    cyc();
    check("first_req", 32'(o_imem_req), 32'h1);
    check("first_addr", o_imem_addr, 32'h0000_3000);
    wait_drain();

    // Delayed ack: request and address held
    imem_delay = 3;
    expect_fetch(32'h0000_3004);
    load(32'h0000_3004);
    check("slow_req", 32'(o_imem_req), 32'h1);
    check("slow_addr", o_imem_addr, 32'h0000_3004);
    wait_drain();

    // Zero-wait memory: o_valid two edges after the load
    imem_delay = 0;
    expect_fetch(32'h0000_300C);
    load(32'h0000_300C);
    check("lat_valid_early", 32'(o_valid), 32'h0);
    cyc();
    check("lat_valid_2cyc", 32'(o_valid), 32'h1);
    wait_drain();

    // Flush while request outstanding: discarded word never presented
    imem_delay = 2;
    expect_fetch(32'h0000_4180);
    load(32'h0000_3008);
    check("disc_addr", o_imem_addr, 32'h0000_3008);
    flush(32'h0000_4180);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (o_imem_req === 1'b1 && o_imem_addr == 32'h0000_4180) found = 1'b1;
      else cyc();
    end
    check("flush_req_seen", 32'(found), 32'h1);
    wait_drain();

    // Misaligned target: no request, NOP with adel
    imem_delay = 1;
    expect_fetch(32'h0000_3006);
    load(32'h0000_3006);
    check("adel_no_req", 32'(o_imem_req), 32'h0);
    wait_drain();

    // Pause in VALID with a load pulsed during the pause
    s_pc = o_pc; s_instr = o_instr; s_cnt = o_fetch_count;
    i_pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_pc_load = (k == 1);
      i_next_pc = 32'h0000_3100;
      cyc();
      check("pause_valid", 32'(o_valid), 32'h1);
      check("pause_pc", o_pc, s_pc);
      check("pause_instr", o_instr, s_instr);
      check("pause_count", o_fetch_count, s_cnt);
    end
    i_pc_load = 1'b0;
    i_pause = 1'b0;
    cyc();
    check("pause_load_ignored", o_pc, s_pc);
    expect_fetch(32'h0000_3104);
    load(32'h0000_3104);
    wait_drain();

    // Pause while request outstanding: ack still completes
    imem_delay = 2;
    expect_fetch(32'h0000_3200);
    load(32'h0000_3200);
    i_pause = 1'b1;
    repeat (4) cyc();
    check("pause_ack_valid", 32'(o_valid), 32'h1);
    check("pause_ack_pc", o_pc, 32'h0000_3200);
    i_pause = 1'b0;
    wait_drain();

    // Randomized mix of loads, flushes and pauses
    for (int it = 0; it < 40; it++) begin
      v = $urandom_range(0, 4);
      a = 32'h0000_3000 + 32'($urandom_range(0, 255)) * 32'd4;
      b = 32'h0000_5000 + 32'($urandom_range(0, 255)) * 32'd4;
      c = 32'h0000_6000 + 32'($urandom_range(0, 255)) * 32'd4;
      imem_delay = $urandom_range(0, 3);
      case (v)
        0: begin
          expect_fetch(a);
          load(a);
        end
        1: begin
          a = a + 32'($urandom_range(1, 3));
          expect_fetch(a);
          load(a);
        end
        2: begin
          expect_fetch(b);
          flush(b);
        end
        3: begin
          imem_delay = $urandom_range(3, 4);
          load(a);
          if ($urandom_range(0, 1) == 1) cyc();
          if ($urandom_range(0, 1) == 1) begin
            flush(b);
            expect_fetch(c);
            flush(c);
          end else begin
            expect_fetch(b);
            flush(b);
          end
        end
        default: begin
          pn = $urandom_range(1, 3);
          i_pause = 1'b1;
          i_next_pc = b;
          i_pc_load = 1'b1;
          repeat (pn) cyc();
          i_pc_load = 1'b0;
          i_pause = 1'b0;
          expect_fetch(a);
          load(a);
        end
      endcase
      wait_drain();
    end

    // Asynchronous reset in the middle of a discard
    imem_delay = 3;
    load(32'h0000_3010);
    flush(32'h0000_4200);
    cyc();
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    model_count = 0;
    repeat (2) cyc();
    imem_delay = 1;
    rst = 1'b0;
    expect_fetch(32'h0000_3000);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC register and instruction-fetch sequencer of the multicycle MIPS core.
- Holds the architectural PC and fetches the word at PC over a req/ack instruction-memory port.
- Presents {pc, instr} to decode/execute, where the branch unit consumes the PC and returns next-PC.
- Reloads from the branch unit's next-PC on a load strobe; supports pause and exception/eret redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- COUNT_W, 32, width of retired-fetch counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_pause  in  1  freeze: no state, PC or counter change (an outstanding imem request stays asserted).
- i_pc_load  in  1  current instruction finished; load i_next_pc.
- i_next_pc  in  32  next PC from branch unit (pc+4, branch or jump target).
- i_flush  in  1  redirect to i_flush_pc; priority over i_pc_load.
- i_flush_pc  in  32  exception vector / EPC.
- o_imem_req  out  1  instruction read request.
- o_imem_addr  out  32  word address (= PC when requesting).
- i_imem_ack  in  1  request accepted; i_imem_rdata valid in same cycle.
- i_imem_rdata  in  32  instruction word.
- o_valid  out  1  o_pc/o_instr hold a fetched instruction.
- o_pc  out  32  PC of presented instruction (feeds branch unit pc input).
- o_instr  out  32  instruction word.
- o_adel  out  1  fetch address misaligned; o_instr forced to 0 (NOP).
- o_fetch_count  out  COUNT_W  number of instructions presented since reset.

Behaviour:
- Reset (async, active-high): state=REQ, pc=RESET_PC, o_valid=0, o_instr=0, o_adel=0, o_imem_req=0, o_fetch_count=0. First request rises in the first cycle after rst deasserts.
- States: REQ, VALID, DISCARD.
- REQ:
  - o_imem_req=1, o_imem_addr=pc.
  - If pc[1:0]!=0: no request; next cycle VALID with o_adel=1, o_instr=0.
  - On i_imem_ack: latch rdata into o_instr, o_valid=1 next cycle, go VALID, count+1.
  - i_flush with ack in the same cycle: drop the data, pc<=i_flush_pc, stay REQ.
  - i_flush without ack: go DISCARD, save flush_pc.
- Request rule: once o_imem_req rises it stays high with stable o_imem_addr until ack, regardless of i_pause or i_flush.
- VALID:
  - o_valid=1, outputs stable.
  - i_flush: pc<=i_flush_pc, o_valid=0, go REQ.
  - Else i_pc_load: pc<=i_next_pc, o_valid=0, o_adel=0, go REQ.
  - Neither: hold.
- DISCARD:
  - Keep req/old addr until ack, ignore rdata, pc<=saved flush_pc, go REQ.
  - A further i_flush in DISCARD overwrites saved flush_pc (latest wins).
- i_pause:
  - Blocks all transitions except ack-completion of an outstanding request. Data is latched, but VALID is not left while paused.
  - i_pc_load/i_flush asserted during pause are ignored (caller reasserts).
- Latency: pc_load to o_valid = 1 cycle (REQ) + imem latency + 1. Zero-wait imem gives 2 cycles.
- o_fetch_count wraps modulo 2^COUNT_W. Counts every entry into VALID, including adel entries.
- No combinational path from imem inputs to o_valid/o_instr; all registered.

Decomposition:
- Shared package cpu_defs: state encoding (REQ=2'd0, VALID=2'd1, DISCARD=2'd2), RESET_PC default, NOP word 32'h0, exception vector constants.
- One optional sub-module, fetch_counter: an enable/wrap counter reusable for other perf counters.
- The FSM and PC register stay in fetch_unit.

Test Plan:
- Reset release, imem ack 1 cycle after req, rdata=32'h2408_0005 -> o_imem_addr=32'h3000, o_valid=1 with o_pc=32'h3000, o_instr=32'h2408_0005, count=1.
- i_pc_load with i_next_pc=32'h3004, ack delayed 3 cycles -> req held with addr 32'h3004 for all 3 cycles, then o_valid; no glitch on addr.
- i_flush (flush_pc=32'h4180) while req outstanding, ack 2 cycles later with 32'hDEAD_BEEF -> DEAD_BEEF never presented; next req addr=32'h4180; count unchanged by discarded word.
- i_next_pc=32'h3006 -> no imem req; o_valid=1, o_adel=1, o_instr=0, o_pc=32'h3006.
- i_pause held 4 cycles in VALID with i_pc_load pulsed during pause -> outputs stable, PC unchanged; a load after pause drops reaches next fetch.
- Async rst asserted mid-DISCARD (off clock edge) -> outputs reach reset values immediately; fetch restarts at 32'h3000.
